dual_port_ram_be_bypass: RTL

DUAL_PORT_RAM_BE_BYPASS -- requirements
Module: dual_port_ram_be_bypass

---
 rtl/dual_port_ram_be_bypass.sv | 130 +++++++++++++
 1 files changed

// File: rtl/dual_port_ram_be_bypass.sv
// True dual-port RAM with per-byte write enables, selectable read-during-write
// behaviour, cross-port bypass and a zero-fill sweep after reset or clear.
module dual_port_ram_be_bypass #(
    parameter int    DATA_WIDTH     = 32,
    parameter int    ADDRESS_WIDTH  = 32,
    parameter int    INDEX_BITS     = 6,
    parameter string RW             = "OLD_DATA",
    parameter int    WRITE_PRIORITY = 1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     clear,
    output logic                     ready,
    input  logic                     we0,
    input  logic                     we1,
    input  logic [DATA_WIDTH/8-1:0]  be0,
    input  logic [DATA_WIDTH/8-1:0]  be1,
    input  logic [DATA_WIDTH-1:0]    data_in0,
    input  logic [DATA_WIDTH-1:0]    data_in1,
    input  logic [ADDRESS_WIDTH-1:0] address0,
    input  logic [ADDRESS_WIDTH-1:0] address1,
    output logic [DATA_WIDTH-1:0]    data_out0,
    output logic [DATA_WIDTH-1:0]    data_out1
);

    localparam int DEPTH = 1 << INDEX_BITS;
    localparam int NB    = DATA_WIDTH / 8;
    localparam bit NEW_DATA = (RW == "NEW_DATA");
    localparam logic [INDEX_BITS:0] LAST = (INDEX_BITS+1)'(DEPTH - 1);

    typedef enum logic {CLEAR, IDLE} state_t;

    state_t                  state, state_next;
    logic [INDEX_BITS:0]     cnt, cnt_next;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic [INDEX_BITS-1:0]   idx0, idx1;
    logic                    hit01, hit10;
    logic [DATA_WIDTH-1:0]   word0, word1;
    logic                    unused_addr_bits;

    function automatic logic [DATA_WIDTH-1:0] merge_bytes(
        input logic [DATA_WIDTH-1:0] old_word,
        input logic [DATA_WIDTH-1:0] wr_data,
        input logic [NB-1:0]         wr_be
    );
        logic [DATA_WIDTH-1:0] w;
        w = old_word;
        for (int k = 0; k < NB; k++) begin
            if (wr_be[k]) w[8*k +: 8] = wr_data[8*k +: 8];
        end
        return w;
    endfunction

    assign ready = (state == IDLE);
    assign unused_addr_bits = ^{address0[ADDRESS_WIDTH-1:INDEX_BITS],
                                address1[ADDRESS_WIDTH-1:INDEX_BITS]};

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            CLEAR: begin
                cnt_next = cnt + 1'b1;
                if (cnt == LAST) state_next = IDLE;
            end
            IDLE: begin
                if (clear) begin
                    state_next = CLEAR;
                    cnt_next   = '0;
                end
            end
            default: state_next = CLEAR;
        endcase
    end

    // Post-write word at each port's index; the priority port's bytes go on last
    always_comb begin
        idx0  = address0[INDEX_BITS-1:0];
        idx1  = address1[INDEX_BITS-1:0];
        hit01 = we1 && (idx1 == idx0);
        hit10 = we0 && (idx0 == idx1);
        word0 = mem[idx0];
        word1 = mem[idx1];
        if (WRITE_PRIORITY == 1) begin
            if (we0)   word0 = merge_bytes(word0, data_in0, be0);
            if (hit01) word0 = merge_bytes(word0, data_in1, be1);
            if (hit10) word1 = merge_bytes(word1, data_in0, be0);
            if (we1)   word1 = merge_bytes(word1, data_in1, be1);
        end else begin
            if (hit01) word0 = merge_bytes(word0, data_in1, be1);
            if (we0)   word0 = merge_bytes(word0, data_in0, be0);
            if (we1)   word1 = merge_bytes(word1, data_in1, be1);
            if (hit10) word1 = merge_bytes(word1, data_in0, be0);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= CLEAR;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_ff @(posedge clock) begin
        if (state == CLEAR) begin
            mem[cnt[INDEX_BITS-1:0]] <= '0;
        end else begin
            if (we0) mem[idx0] <= word0;
            if (we1) mem[idx1] <= word1;
        end
    end

    // Registered read stage: outputs forced to zero whenever the array is sweeping
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            data_out0 <= '0;
            data_out1 <= '0;
        end else if (state == IDLE) begin
            data_out0 <= NEW_DATA ? word0 : mem[idx0];
            data_out1 <= NEW_DATA ? word1 : mem[idx1];
        end else begin
            data_out0 <= '0;
            data_out1 <= '0;
        end
    end

endmodule
